led_pattern_gen: RTL and testbench
==================================

# led_pattern_gen

Downstream consumer of the free-running 32-bit counter value. It derives a one-cycle tick from a selectable counter bit and drives an LED in one of four patterns: off, solid, blink, or breathe. Breathe is a PWM whose duty ramps up and down, compared against the counter's low bits. Its outputs feed the board LED pin and any logic that needs a slow periodic strobe.

## Interface
- `TAP_BIT`, default 23: counter bit whose rising edge generates `tick`; legal range 1..31.
- `PWM_BITS`, default 8: width of the PWM compare and of `duty`; legal range 1..`TAP_BIT`.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset, synchronous and active-high.
- `count` in 32: free-running counter value from the upstream counter stage, same clock domain.
- `mode` in 2: 00 OFF, 01 SOLID, 10 BLINK, 11 BREATHE.
- `led` out 1: registered LED drive.
- `tick` out 1: registered one-cycle pulse on each rising edge of `count[TAP_BIT]`.
- `duty` out `PWM_BITS`: current breathe duty; 0 outside BREATHE.

## Operation
- **Edge detect:** `tap_q` <= `count[TAP_BIT]` every cycle.
  - Edge = `count[TAP_BIT]` & ~`tap_q`.
  - `tick` <= edge.
- **FSM states:** S_OFF, S_SOLID, S_BLINK, S_UP, S_DOWN.
- **Mode decode target:** 00→S_OFF, 01→S_SOLID, 10→S_BLINK, 11→S_UP.
- **Mode change:** when the decoded target differs from the current state's mode, enter the target next cycle. S_UP and S_DOWN both count as BREATHE.
  - Entering S_BLINK: blink phase <= 0.
  - Entering S_UP: `duty` <= 0.
- **Mode change vs. edge:** a mode change takes priority over an edge in the same cycle. The pattern does not advance, but `tick` still pulses.
- **S_OFF:** `led` <= 0.
- **S_SOLID:** `led` <= 1.
- **S_BLINK:** on each edge, phase <= ~phase; `led` <= phase (the registered value).
- **S_UP, on edge:**
  - `duty` == MAX (2^`PWM_BITS`−1): go to S_DOWN, `duty` <= MAX−1.
  - Otherwise: `duty` <= `duty`+1.
- **S_DOWN, on edge:**
  - `duty` == 0: go to S_UP, `duty` <= 1.
  - Otherwise: `duty` <= `duty`−1.
- **Breathe LED:** in S_UP and S_DOWN, `led` <= (`count[PWM_BITS-1:0]` < `duty`), unsigned compare. `duty`=0 means LED always off; MAX means off for 1 of 2^`PWM_BITS` slots.
- **`duty` outside BREATHE:** forced to 0.
- **Wrap-around:** counter wrap 0xFFFFFFFF→0 is a falling edge of the tap, so no tick. Arbitrary jumps in `count` are handled purely by the sampled bit.

## Timing
- **Reset values:** `led`=0, `tick`=0, `duty`=0, state=S_OFF, phase=0, `tap_q`=1.
  - `tap_q`=1 suppresses a spurious tick if the tap bit is already 1 when reset releases.
- **`rst` mid-operation:** all state returns to reset values at the next edge, overriding everything. `mode` is first acted on in the cycle after `rst` deasserts, so the new state is visible one cycle later.
- **Tick latency:** `tick` is high the cycle after the first sample where the tap bit reads 1 following a 0. Pulse width is exactly 1 cycle.
- **Blink / duty latency:** phase and `duty` update on the same edge that registers `tick`.
- **LED latency:** `led` reflects the `count` sampled one cycle earlier (1-cycle latency).
- **Mode latency:** a mode change is visible on `led` within 2 cycles.

## Structure
- **Package `led_pattern_pkg`:**
  - mode encodings `MODE_OFF`, `MODE_SOLID`, `MODE_BLINK`, `MODE_BREATHE`;
  - the state enum;
  - `MODE_W`=2.
- **Sub-module `tap_edge_detect`** (params: bit index; in: `clk`, `rst`, `count`; out: `edge`), instantiated once.
- **Top level:** FSM, duty ramp, PWM compare, output registers.

## Test plan
All scenarios use `TAP_BIT`=4 and `PWM_BITS`=3 (MAX=7); `count` increments by 1 per cycle unless stated.
- **Reset:** `rst`=1 for 2 cycles with `count`=0x1F, then release with `count` held at 0x10 → `led`=0, `tick`=0, `duty`=0 throughout; no tick.
- **Tick:**
  - Start `count` at 0 → `tick` pulses exactly once per 32 cycles, 1 cycle after `count`=0x10 is sampled.
  - Jump `count` from 0xFFFFFFFE through 0xFFFFFFFF to 0 → no tick at the wrap.
- **Blink:** `mode`=10 → `led` goes 0→1 after the first tick, 1→0 after the second; constant between ticks.
- **Breathe:**
  - `mode`=11 → `duty` over successive ticks: 0,1,…,7,6,…,0,1.
  - While `duty`=3 → `led`=1 exactly when the previous cycle's `count[2:0]` ∈ {0,1,2}.
- **Mode change on tick:** change `mode` BLINK→BREATHE in the same cycle the tap edge is detected → next state S_UP with `duty`=0; no blink toggle; `tick` still pulses.
- **Mid-run reset:** assert `rst` in BREATHE at `duty`=5 → next cycle `duty`=0, `led`=0, state S_OFF. After release, with `mode` still 11, `duty` restarts at 0 and ramps up.

Source files
------------

// File: rtl/led_pattern_gen_pkg.sv
// Shared types for the LED pattern generator: mode encodings, FSM states and
// the mapping between them.
package led_pattern_pkg;
   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      MODE_OFF     = 2'b00,
      MODE_SOLID   = 2'b01,
      MODE_BLINK   = 2'b10,
      MODE_BREATHE = 2'b11
   } mode_e;

   typedef enum logic [2:0] {
      S_OFF,
      S_SOLID,
      S_BLINK,
      S_UP,
      S_DOWN
   } state_e;

   // Breathe is split into two ramp states that both report as one mode.
   function automatic mode_e state_mode(state_e s);
      case (s)
         S_SOLID:       return MODE_SOLID;
         S_BLINK:       return MODE_BLINK;
         S_UP, S_DOWN:  return MODE_BREATHE;
         default:       return MODE_OFF;
      endcase
   endfunction

   function automatic state_e mode_target(mode_e m);
      case (m)
         MODE_SOLID:   return S_SOLID;
         MODE_BLINK:   return S_BLINK;
         MODE_BREATHE: return S_UP;
         default:      return S_OFF;
      endcase
   endfunction
endpackage

// File: rtl/led_pattern_gen_if.sv
// Counter/mode inputs and LED/tick/duty outputs of the pattern generator.
interface led_pattern_gen_if #(parameter int PWM_BITS = 8) ();
   import led_pattern_pkg::*;

   logic [31:0]         count;
   logic [MODE_W-1:0]   mode;
   logic                led;
   logic                tick;
   logic [PWM_BITS-1:0] duty;

   modport master (output count, output mode, input led, input tick, input duty);
   modport slave  (input count, input mode, output led, output tick, output duty);
endinterface

// File: rtl/led_pattern_gen_tap.sv
// Rising-edge detector on one bit of the free-running counter.
module tap_edge_detect #(
   parameter int BIT = 23
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] count,
   output logic        rise
);
   logic tap_q;
   logic count_unused;

   assign count_unused = ^count;

   // Reset high so a tap bit already at 1 on release is not seen as an edge.
   always_ff @(posedge clk) begin
      if (rst) tap_q <= 1'b1;
      else     tap_q <= count[BIT];
   end

   assign rise = count[BIT] & ~tap_q;
endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: OFF / SOLID / BLINK / BREATHE driven from a counter tap.
module led_pattern_gen
   import led_pattern_pkg::*;
#(
   parameter int TAP_BIT  = 23,
   parameter int PWM_BITS = 8
) (
   input  logic             clk,
   input  logic             rst,
   led_pattern_gen_if.slave bus
);
   localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

   state_e              state, state_nxt;
   logic [PWM_BITS-1:0] duty, duty_nxt;
   logic                phase, phase_nxt;
   logic                led, led_nxt;
   logic                tick;
   logic                rise;
   logic                mode_chg;

   tap_edge_detect #(.BIT(TAP_BIT)) u_tap (
      .clk   (clk),
      .rst   (rst),
      .count (bus.count),
      .rise  (rise)
   );

   assign mode_chg = (state_mode(state) != mode_e'(bus.mode));

   always_comb begin
      state_nxt = state;
      duty_nxt  = duty;
      phase_nxt = phase;
      led_nxt   = 1'b0;

      case (state)
         S_SOLID:      led_nxt = 1'b1;
         S_BLINK:      led_nxt = phase;
         S_UP, S_DOWN: led_nxt = (bus.count[PWM_BITS-1:0] < duty);
         default:      led_nxt = 1'b0;
      endcase

      // A mode change wins over a same-cycle edge; the pattern restarts.
      if (mode_chg) begin
         state_nxt = mode_target(mode_e'(bus.mode));
         duty_nxt  = '0;
         phase_nxt = 1'b0;
      end else begin
         case (state)
            S_BLINK: if (rise) phase_nxt = ~phase;
            S_UP: if (rise) begin
               if (duty == DUTY_MAX) begin
                  state_nxt = S_DOWN;
                  duty_nxt  = DUTY_MAX - 1'b1;
               end else begin
                  duty_nxt = duty + 1'b1;
               end
            end
            S_DOWN: if (rise) begin
               if (duty == '0) begin
                  state_nxt = S_UP;
                  duty_nxt  = PWM_BITS'(1);
               end else begin
                  duty_nxt = duty - 1'b1;
               end
            end
            default: duty_nxt = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_OFF;
         duty  <= '0;
         phase <= 1'b0;
         led   <= 1'b0;
         tick  <= 1'b0;
      end else begin
         state <= state_nxt;
         duty  <= duty_nxt;
         phase <= phase_nxt;
         led   <= led_nxt;
         tick  <= rise;
      end
   end

   assign bus.led  = led;
   assign bus.tick = tick;
   assign bus.duty = duty;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomized self-checking bench for led_pattern_gen (TAP_BIT=4, PWM_BITS=3).
module tb_led_pattern_gen;
   localparam int TAP = 4;
   localparam int PW  = 3;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   led_pattern_gen_if #(.PWM_BITS(PW)) bus ();

   led_pattern_gen #(.TAP_BIT(TAP), .PWM_BITS(PW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: pattern is a function of edges seen since the mode was entered.
   int         m_n;
   logic [1:0] m_mode;
   logic       m_tap, m_led, m_tick;
   logic [2:0] m_duty;

   function automatic logic [2:0] tri_duty(input int n);
      int k;
      k = n % 14;
      return (k <= 7) ? 3'(k) : 3'(14 - k);
   endfunction

   always @(posedge clk) begin
      logic rise;
      rise = bus.count[TAP] & ~m_tap;
      if (rst) begin
         m_tap = 1'b1; m_tick = 1'b0; m_led = 1'b0; m_mode = 2'b00; m_n = 0;
      end else begin
         m_tick = rise;
         m_tap  = bus.count[TAP];
         case (m_mode)
            2'b00:   m_led = 1'b0;
            2'b01:   m_led = 1'b1;
            2'b10:   m_led = m_n[0];
            default: m_led = (bus.count[2:0] < tri_duty(m_n));
         endcase
         if (bus.mode != m_mode) begin
            m_mode = bus.mode;
            m_n    = 0;
         end else if (rise) begin
            m_n++;
         end
      end
      m_duty = (m_mode == 2'b11) ? tri_duty(m_n) : 3'd0;
   end

   task automatic step(input logic [31:0] c, input logic [1:0] m, input logic r);
      bus.count = c;
      bus.mode  = m;
      rst       = r;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 6; i++) begin
         step((i < 2) ? 32'h1F : 32'h10, 2'b00, (i < 2));
         checks++;
         if ({bus.led, bus.tick, bus.duty} !== 5'b0) begin
            errors++;
            $display("FAIL reset cyc %0d: led=%b tick=%b duty=%0d, want 0/0/0", i, bus.led, bus.tick, bus.duty);
         end
      end
   endtask

   task automatic test_tick();
      logic [31:0] c = 0;
      int ticks = 0;
      for (int i = 0; i < 96; i++) begin
         step(c, 2'b01, 1'b0);
         checks++;
         if (bus.tick !== (c[4:0] == 5'h10) || bus.tick !== m_tick || bus.led !== m_led) begin
            errors++;
            $display("FAIL tick cnt=%0h: tick=%b led=%b, want tick=%b led=%b", c, bus.tick, bus.led, (c[4:0] == 5'h10), m_led);
         end
         ticks += int'(bus.tick);
         c++;
      end
      checks++;
      if (ticks != 3) begin
         errors++;
         $display("FAIL tick_count: got %0d, want 3", ticks);
      end
      for (int i = 0; i < 4; i++) begin
         step(32'hFFFF_FFFE + 32'(i), 2'b01, 1'b0);
         checks++;
         if (bus.tick !== 1'b0) begin
            errors++;
            $display("FAIL tick_wrap step %0d: tick=%b, want 0", i, bus.tick);
         end
      end
   endtask

   task automatic test_blink();
      logic [31:0] c = $urandom;
      logic prev_led = 1'b0, prev_tick = 1'b0;
      for (int i = 0; i < 200; i++) begin
         step(c, 2'b10, 1'b0);
         checks++;
         if ({bus.led, bus.tick, bus.duty} !== {m_led, m_tick, m_duty}) begin
            errors++;
            $display("FAIL blink cyc %0d: led=%b tick=%b duty=%0d, want %b/%b/%0d", i, bus.led, bus.tick, bus.duty, m_led, m_tick, m_duty);
         end
         if (i >= 2) begin
            checks++;
            if ((bus.led !== prev_led) !== prev_tick) begin
               errors++;
               $display("FAIL blink_toggle cyc %0d: led=%b prev=%b after tick=%b", i, bus.led, prev_led, prev_tick);
            end
         end
         prev_led  = bus.led;
         prev_tick = bus.tick;
         c++;
      end
   endtask

   task automatic test_breathe();
      logic [2:0]  exp_seq [16] = '{1,2,3,4,5,6,7,6,5,4,3,2,1,0,1,2};
      logic [31:0] c = {$urandom_range(0, 1000), 5'h00};
      logic [2:0]  prev_duty;
      int k = 0;
      for (int i = 0; i < 700 && k < 16; i++) begin
         prev_duty = m_duty;
         step(c, 2'b11, 1'b0);
         checks++;
         if ({bus.led, bus.tick, bus.duty} !== {m_led, m_tick, m_duty}) begin
            errors++;
            $display("FAIL breathe cyc %0d: led=%b tick=%b duty=%0d, want %b/%b/%0d", i, bus.led, bus.tick, bus.duty, m_led, m_tick, m_duty);
         end
         if (prev_duty == 3'd3 && i > 0) begin
            checks++;
            if (bus.led !== (c[2:0] < 3'd3)) begin
               errors++;
               $display("FAIL breathe_pwm3 cnt=%0h: led=%b, want %b", c, bus.led, (c[2:0] < 3'd3));
            end
         end
         if (bus.tick === 1'b1 && i > 0) begin
            checks++;
            if (bus.duty !== exp_seq[k]) begin
               errors++;
               $display("FAIL breathe_seq tick %0d: duty=%0d, want %0d", k, bus.duty, exp_seq[k]);
            end
            k++;
         end
         c++;
      end
      checks++;
      if (k != 16) begin
         errors++;
         $display("FAIL breathe_timeout: saw %0d ticks, want 16", k);
      end
   endtask

   task automatic test_mode_change_on_tick();
      for (int i = 0; i < 16; i++) step(32'(i), 2'b10, 1'b0);
      step(32'h10, 2'b11, 1'b0);
      checks++;
      if ({bus.tick, bus.duty} !== {1'b1, 3'd0} || bus.led !== m_led) begin
         errors++;
         $display("FAIL mode_chg_tick: tick=%b duty=%0d led=%b, want 1/0/%b", bus.tick, bus.duty, bus.led, m_led);
      end
      for (int i = 17; i < 40; i++) begin
         step(32'(i), 2'b11, 1'b0);
         checks++;
         if ({bus.led, bus.tick, bus.duty} !== {m_led, m_tick, m_duty} || bus.duty !== 3'd0 || bus.led !== 1'b0) begin
            errors++;
            $display("FAIL mode_chg_after cnt=%0h: led=%b duty=%0d, want 0/0", i, bus.led, bus.duty);
         end
      end
   endtask

   task automatic test_mid_reset();
      logic [31:0] c = 32'd40;
      bit found = 0;
      for (int i = 0; i < 600 && !found; i++) begin
         step(c, 2'b11, 1'b0);
         c++;
         found = (m_duty == 3'd5);
      end
      checks++;
      if (!found || bus.duty !== 3'd5) begin
         errors++;
         $display("FAIL mid_reset_reach: duty=%0d, want 5", bus.duty);
      end
      step(c, 2'b11, 1'b1);
      c++;
      checks++;
      if ({bus.led, bus.tick, bus.duty} !== 5'b0) begin
         errors++;
         $display("FAIL mid_reset: led=%b tick=%b duty=%0d, want 0/0/0", bus.led, bus.tick, bus.duty);
      end
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         step(c, 2'b11, 1'b0);
         c++;
         checks++;
         if ({bus.led, bus.tick, bus.duty} !== {m_led, m_tick, m_duty} || bus.duty > 3'd1) begin
            errors++;
            $display("FAIL mid_reset_ramp cyc %0d: led=%b duty=%0d, want %b/%0d", i, bus.led, bus.duty, m_led, m_duty);
         end
         found = (bus.duty == 3'd1);
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL mid_reset_timeout: duty never reached 1");
      end
   endtask

   task automatic test_random();
      logic [31:0] c = $urandom;
      logic [1:0]  m = 2'b11;
      logic        r;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 3) c = $urandom;
         else                           c++;
         if ($urandom_range(0, 199) < 3) m = 2'($urandom);
         r = ($urandom_range(0, 399) == 0);
         step(c, m, r);
         checks++;
         if ({bus.led, bus.tick, bus.duty} !== {m_led, m_tick, m_duty}) begin
            errors++;
            $display("FAIL random cyc %0d: led=%b tick=%b duty=%0d, want %b/%b/%0d", i, bus.led, bus.tick, bus.duty, m_led, m_tick, m_duty);
         end
      end
   endtask

   initial begin
      rst       = 1'b1;
      bus.count = 32'h1F;
      bus.mode  = 2'b00;
      test_reset();
      test_tick();
      test_blink();
      test_breathe();
      test_mode_change_on_tick();
      test_mid_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
